// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, carry renormalise and IEEE-754 pack for the FP multiply path.
// Two-stage valid/ready pipeline: stage 1 rounds, stage 2 classifies range and packs.
module fp_round_pack #(
  parameter int E  = 8,
  parameter int M  = 23,
  parameter int EW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [M-1:0]  in_mant,
  input  logic          in_round,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [E+M:0]  out_result,
  output logic          out_overflow,
  output logic          out_underflow,
  output logic          out_inexact
);

  localparam logic [EW:0] EXP_MAX = (EW+1)'((1 << E) - 1);

  // vld_pipe[1] = stage-1 valid, vld_pipe[2] = output valid
  logic [2:1] vld_pipe;
  logic       s1_en, s2_en;

  assign s2_en     = !vld_pipe[2] | out_ready;
  assign s1_en     = !vld_pipe[1] | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = vld_pipe[2];

  logic          inc;
  logic [M:0]    sum;
  logic [EW:0]   exp1;

  always_comb begin
    inc  = in_round & (in_sticky | in_mant[0]);
    sum  = {1'b0, in_mant} + (M+1)'(inc);
    // sign-extend so negative pre-round exponents never wrap into range
    exp1 = {in_exp[EW-1], in_exp} + (EW+1)'(sum[M]);
  end

  logic          s1_sign, s1_inexact;
  logic [EW:0]   s1_exp;
  logic [M-1:0]  s1_frac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_frac     <= '0;
      s1_inexact  <= 1'b0;
    end else if (s1_en) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_exp     <= exp1;
        s1_frac    <= sum[M-1:0];
        s1_inexact <= in_round | in_sticky;
      end
    end
  end

  logic ovf, unf;

  always_comb begin
    ovf = !s1_exp[EW] && (s1_exp >= EXP_MAX);
    unf = s1_exp[EW] || (s1_exp == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[2]   <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_en) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        out_overflow  <= ovf;
        out_underflow <= unf;
        if (ovf) begin
          out_result  <= {s1_sign, {E{1'b1}}, {M{1'b0}}};
          out_inexact <= 1'b1;
        end else if (unf) begin
          out_result  <= {s1_sign, {(E+M){1'b0}}};
          out_inexact <= 1'b1;
        end else begin
          out_result  <= {s1_sign, s1_exp[E-1:0], s1_frac};
          out_inexact <= s1_inexact;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: significand-level rounding model, scoreboard checked on
// every output handshake, stall-hold checks, reset flush and literal pins.
module tb_fp_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_round, in_sticky;
  logic [9:0]  in_exp;
  logic [22:0] in_mant;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  logic [34:0] exp_q[$];
  logic        stalled = 1'b0;
  logic [34:0] held;

  fp_round_pack #(.E(8), .M(23), .EW(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_round(in_round), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Value-level model: 24-bit significand with hidden one, round, renormalise, range check.
  // Returns {word[31:0], overflow, underflow, inexact}.
  function automatic logic [34:0] model(input logic sg, input int ex, input int mant,
                                        input bit r, input bit s);
    int sig;
    int e;
    bit up;
    sig = (1 << 23) + mant;
    e   = ex;
    up  = r && (s || (sig % 2 == 1));
    if (up) sig = sig + 1;
    if (sig >= (1 << 24)) begin
      sig = sig / 2;
      e   = e + 1;
    end
    if (e >= 255) return {sg, 8'hFF, 23'h0, 3'b101};
    if (e <= 0)   return {sg, 31'h0, 3'b011};
    return {sg, 8'(e), 23'(sig % (1 << 23)), 2'b00, (r | s)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_word", 64'({out_result, out_overflow, out_underflow, out_inexact}),
              64'(held));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
        else check("result", 64'({out_result, out_overflow, out_underflow, out_inexact}),
                   64'(exp_q.pop_front()));
      end
      stalled = out_valid && !out_ready;
      held    = {out_result, out_overflow, out_underflow, out_inexact};
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sign, int'($signed(in_exp)), int'(in_mant), in_round, in_sticky));
    end
  end

  task automatic send(input logic sg, input int ex, input int mant, input bit r, input bit s);
    int k;
    in_sign   = sg;
    in_exp    = 10'(ex);
    in_mant   = 23'(mant);
    in_round  = r;
    in_sticky = s;
    in_valid  = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_round = 1'b0; in_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_word", 64'({out_result, out_overflow, out_underflow, out_inexact}), 64'd0);
    rst = 1'b0;

    // hand-computed pins on the model itself
    check("pin_T1", 64'(model(0, 127, 'h000000, 1, 0)), 64'({32'h3F800000, 3'b001}));
    check("pin_T2", 64'(model(0, 127, 'h000001, 1, 0)), 64'({32'h3F800002, 3'b001}));
    check("pin_T3", 64'(model(0, 127, 'h7FFFFF, 1, 0)), 64'({32'h40000000, 3'b001}));
    check("pin_T4o", 64'(model(0, 254, 'h7FFFFF, 1, 1)), 64'({32'h7F800000, 3'b101}));
    check("pin_T4u", 64'(model(1, -3, 'h7FFFFF, 1, 1)), 64'({32'h80000000, 3'b011}));
    check("pin_max", 64'(model(0, 254, 'h7FFFFF, 0, 0)), 64'({32'h7F7FFFFF, 3'b000}));

    // directed vectors back to back, no stall
    send(0, 127, 'h000000, 1, 0);
    send(0, 127, 'h000001, 1, 0);
    send(0, 127, 'h7FFFFF, 1, 0);
    send(0, 254, 'h7FFFFF, 1, 1);
    send(1, -3,  'h7FFFFF, 1, 1);
    send(0, 254, 'h7FFFFF, 0, 0);
    send(1, 1,   'h000000, 0, 0);
    send(0, 0,   'h7FFFFF, 1, 1);
    send(0, 255, 'h000000, 0, 0);
    send(1, 130, 'h123456, 1, 1);
    send(0, 130, 'h123455, 0, 1);
    send(0, 100, 'h2AAAAB, 1, 0);
    repeat (4) @(posedge clk);

    // T5: stall with two buffered, then release while more are queued
    #1 out_ready = 1'b0;
    send(0, 127, 'h000010, 0, 1);
    send(1, 128, 'h400000, 1, 0);
    check("T5_in_ready_full", 64'(in_ready), 64'd0);
    check("T5_out_valid_held", 64'(out_valid), 64'd1);
    fork
      begin
        send(0, 129, 'h7FFFFF, 1, 1);
        send(1, 126, 'h000003, 1, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    check("T5_drained", 64'(exp_q.size()), 64'd0);

    // T6: reset with two ops in flight
    #1 out_ready = 1'b0;
    send(0, 127, 'h000000, 0, 0);
    send(0, 128, 'h000000, 0, 0);
    rst = 1'b1;
    #1;
    check("T6_out_valid_rst", 64'(out_valid), 64'd0);
    check("T6_in_ready_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    send(0, 127, 'h000001, 1, 0);
    check("T6_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("T6_out_valid", 64'(out_valid), 64'd1);
    check("T6_word", 64'({out_result, out_inexact}), 64'({32'h3F800002, 1'b1}));
    repeat (4) @(posedge clk);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check("output_count", 64'(n_out), 64'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
